key_debounce: RTL and testbench

Input-side counterpart to the LED toggle logic: conditions raw push-button inputs from the board into clean, clock-synchronous key events. Each key is synchronised, debounced with a stability counter, and converted to a level plus single-cycle press, release and long-press pulses. Sits between the board key pins and any control logic that drives the LEDs.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_debounce_ch.sv | 140 ++++++++++++++
 rtl/key_debounce.sv | 46 ++++
 tb/tb_key_debounce.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg
// Shared constants and the per-channel state encoding for the key debouncer.
// No ports; imported by key_debounce and key_debounce_ch.
package key_pkg;

    // Defaults for a 50 MHz clock: 20 ms debounce, 1 s long press.
    localparam int DEBOUNCE_CYCLES_50MHZ = 1_000_000;
    localparam int LONG_CYCLES_50MHZ     = 50_000_000;

    // Bit 1 of the encoding is the debounced level (pressed in HELD and RELEASE_WAIT).
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_ch_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
// One key channel: two-flop synchroniser, debounce counter, channel FSM and
// long-press hold counter. All outputs are registered.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw key pin (asynchronous)
//   key_state    debounced level, 1 = pressed
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   key_long     1-cycle pulse once per press after LONG_CYCLES held
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | released and stable
// PRESS_WAIT   | sample reads pressed, counting toward press acceptance
// HELD         | pressed and stable, hold counter running
// RELEASE_WAIT | sample reads released, counting toward release acceptance
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int LONG_CYCLES     = LONG_CYCLES_50MHZ,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic              PIN_IDLE = ACTIVE_LOW;

    logic [1:0]        sync_q;
    key_ch_state_e     state_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              sample;
    logic              level;

    // Normalised sample: 1 = pressed regardless of pin polarity.
    assign sample = sync_q[1] ^ PIN_IDLE;
    assign level  = state_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= {2{PIN_IDLE}};
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_in};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            // Entering a wait state counts the first differing edge, so the
            // counter reaches DB_LAST after DEBOUNCE_CYCLES-1 edges and the
            // next differing edge accepts.
            case (state_q)
                IDLE: begin
                    db_cnt_q <= '0;
                    if (sample) begin
                        state_q  <= PRESS_WAIT;
                        db_cnt_q <= DB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!sample) begin
                        state_q  <= IDLE;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q  <= HELD;
                        db_cnt_q <= '0;
                        press_q  <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                HELD: begin
                    db_cnt_q <= '0;
                    if (!sample) begin
                        state_q  <= RELEASE_WAIT;
                        db_cnt_q <= DB_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (sample) begin
                        state_q  <= HELD;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q   <= IDLE;
                        db_cnt_q  <= '0;
                        release_q <= 1'b1;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    db_cnt_q <= '0;
                end
            endcase

            // Hold counter only runs on the accepted level, so it is still 0
            // on the press edge and key_long can never coincide with key_press.
            if (level) begin
                if (hold_q != HOLD_MAX) begin
                    hold_q <= hold_q + HOLD_W'(1);
                    if (hold_q + HOLD_W'(1) == HOLD_MAX) begin
                        long_q <= 1'b1;
                    end
                end
            end else begin
                hold_q <= '0;
            end
        end
    end

    assign key_state   = level;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce
// Conditions NUM_KEYS raw push-button pins into clean, clock-synchronous key
// events: debounced level plus press, release and long-press pulses.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   rst_n        asynchronous active-low reset
//   key_in       raw key pins
//   key_state    debounced levels, 1 = pressed
//   key_press    1-cycle pulses on accepted press
//   key_release  1-cycle pulses on accepted release
//   key_long     1-cycle pulses once per press after LONG_CYCLES held
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int LONG_CYCLES     = LONG_CYCLES_50MHZ,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_in      (key_in[g]),
            .key_state   (key_state[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    int checks = 0;
    int errors = 0;

    key_debounce #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic bad;
        int   long_at;
        int   long_cnt;

        // 1: reset, then a clean press on key 0
        rst_n  = 1'b0;
        key_in = 4'b1111;
        tick_n(3);
        check("rst_state",   32'(key_state),   32'h0);
        check("rst_press",   32'(key_press),   32'h0);
        check("rst_release", 32'(key_release), 32'h0);
        check("rst_long",    32'(key_long),    32'h0);
        rst_n = 1'b1;
        tick_n(2);
        key_in = 4'b1110;
        tick_n(5);
        check("t1_before", 32'(key_state[0]), 32'h0);
        tick();
        check("t1_state", 32'(key_state), 32'h1);
        check("t1_press", 32'(key_press), 32'h1);
        tick();
        check("t1_press_1cyc", 32'(key_press), 32'h0);

        // 2: bounce on key 1 (2-cycle glitches), then stable low
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_in[1] = (i % 2 == 1);
            for (int j = 0; j < 2; j++) begin
                tick();
                bad |= key_press[1] | key_state[1];
            end
        end
        key_in[1] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            bad |= key_press[1] | key_state[1];
        end
        check("t2_bounce_quiet", 32'(bad), 32'h0);
        tick();
        check("t2_press", 32'(key_press[1]), 32'h1);
        check("t2_state", 32'(key_state[1]), 32'h1);

        // 3: long press on key 2, no repeat, then release
        key_in[2] = 1'b0;
        tick_n(6);
        check("t3_press", 32'(key_press[2]), 32'h1);
        check("t3_no_long_with_press", 32'(key_long[2]), 32'h0);
        tick_n(9);
        check("t3_long_early", 32'(key_long[2]), 32'h0);
        tick();
        check("t3_long", 32'(key_long[2]), 32'h1);
        long_cnt = 0;
        for (int j = 0; j < 50; j++) begin
            tick();
            if (key_long[2]) long_cnt++;
        end
        check("t3_no_repeat", 32'(long_cnt), 32'h0);
        key_in[2] = 1'b1;
        tick_n(5);
        check("t3_rel_early", 32'({key_state[2], key_release[2]}), 32'h2);
        tick();
        check("t3_release", 32'({key_state[2], key_release[2]}), 32'h1);

        // 4: 3-cycle release glitch on held key 3 must not release or reset hold
        key_in[3] = 1'b0;
        tick_n(6);
        check("t4_press", 32'(key_press[3]), 32'h1);
        bad      = 1'b0;
        long_at  = -1;
        long_cnt = 0;
        for (int t = 1; t <= 14; t++) begin
            if (t == 3) key_in[3] = 1'b1;
            if (t == 6) key_in[3] = 1'b0;
            tick();
            bad |= key_release[3] | ~key_state[3];
            if (key_long[3]) begin
                long_at = t;
                long_cnt++;
            end
        end
        check("t4_glitch_quiet", 32'(bad), 32'h0);
        check("t4_long_at", 32'(long_at), 32'd10);
        check("t4_long_once", 32'(long_cnt), 32'd1);

        // 5: simultaneous press on all keys
        key_in = 4'b1111;
        tick_n(12);
        check("t5_idle", 32'(key_state), 32'h0);
        key_in = 4'b0000;
        tick_n(5);
        check("t5_early", 32'(key_press), 32'h0);
        tick();
        check("t5_press", 32'(key_press), 32'hF);
        check("t5_state", 32'(key_state), 32'hF);
        tick();
        check("t5_press_1cyc", 32'(key_press), 32'h0);

        // 6: asynchronous reset in the middle of a press count
        key_in = 4'b1111;
        tick_n(12);
        key_in = 4'b1101;
        tick_n(8);
        check("t6_pre", 32'(key_state), 32'h2);
        key_in = 4'b1100;
        tick_n(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_state", 32'(key_state), 32'h0);
        check("t6_async_press", 32'(key_press), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick_n(5);
        check("t6_restart_early", 32'(key_state), 32'h0);
        tick();
        check("t6_restart_state", 32'(key_state), 32'h3);
        check("t6_restart_press", 32'(key_press), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
